// File: rtl/multi_nch_disp.sv
// Multi-channel display multiplexer: manual channel select or timed auto-scan, registered outputs.
// Define MULTI_NCH_DISP_AUTOSCAN_EN to build the AUTO state and dwell counter.
module multi_nch_disp #(
  parameter int unsigned CH    = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   EN,
  input  logic [$clog2(CH)-1:0]  Test,
  input  logic                   auto,
  input  logic [DW-1:0]          Data0,
  input  logic [(CH-1)*DW-1:0]   Test_data,
  input  logic [CH*8-1:0]        point_in,
  input  logic [CH*8-1:0]        LES,
  output logic [DW-1:0]          Disp_num,
  output logic [7:0]             point_out,
  output logic [7:0]             blink_out,
  output logic [$clog2(CH)-1:0]  cur_ch
);

  localparam int unsigned SW = $clog2(CH);
  localparam logic [DW-1:0] DispRst = DW'(32'hAA5555AA);

  logic [DW-1:0] disp_q;
  logic [7:0]    blink_q;
  logic [7:0]    point_q;

  logic [SW-1:0] test_ch;
  logic [SW-1:0] ch_d;
  logic [DW-1:0] disp_sel;
  logic [7:0]    point_sel;
  logic [7:0]    blink_sel;

  // Out-of-range manual selects fall back to channel 0.
  always_comb begin
    test_ch = Test;
    if (32'(Test) >= CH) begin
      test_ch = '0;
    end
  end

`ifdef MULTI_NCH_DISP_AUTOSCAN_EN
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [0:0] {StManual, StAuto} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    ch_d    = test_ch;
    unique case (state_q)
      StManual: begin
        if (auto) begin
          state_d = StAuto;
          ch_d    = cur_ch;
        end
      end
      StAuto: begin
        if (!auto) begin
          state_d = StManual;
        end else if (cnt_q == CW'(DWELL - 1)) begin
          ch_d = (cur_ch == SW'(CH - 1)) ? '0 : cur_ch + 1'b1;
        end else begin
          ch_d  = cur_ch;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StManual;
      end
    endcase
  end
`else
  logic unused_auto;
  assign unused_auto = auto;

  always_comb begin
    ch_d = test_ch;
  end
`endif

  // Channel 0 comes from the latched CPU registers; others pass straight through.
  always_comb begin
    disp_sel  = disp_q;
    point_sel = point_q;
    blink_sel = blink_q;
    for (int unsigned k = 1; k < CH; k++) begin
      if (32'(ch_d) == k) begin
        disp_sel  = Test_data[(k-1)*DW +: DW];
        point_sel = point_in[k*8 +: 8];
        blink_sel = LES[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q    <= DispRst;
      blink_q   <= 8'hFF;
      point_q   <= 8'h00;
      cur_ch    <= '0;
      Disp_num  <= DispRst;
      point_out <= 8'h00;
      blink_out <= 8'hFF;
`ifdef MULTI_NCH_DISP_AUTOSCAN_EN
      state_q   <= StManual;
      cnt_q     <= '0;
`endif
    end else begin
      if (EN) begin
        disp_q  <= Data0;
        blink_q <= LES[7:0];
        point_q <= point_in[7:0];
      end
      cur_ch    <= ch_d;
      Disp_num  <= disp_sel;
      point_out <= point_sel;
      blink_out <= blink_sel;
`ifdef MULTI_NCH_DISP_AUTOSCAN_EN
      state_q   <= state_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_multi_nch_disp.sv
// Directed self-checking bench for multi_nch_disp (CH=8, DW=32, DWELL=4).
module tb_multi_nch_disp;
  localparam int CH    = 8;
  localparam int DW    = 32;
  localparam int DWELL = 4;
  localparam int SW    = $clog2(CH);

  logic                 clk = 1'b0;
  logic                 rst, EN, auto;
  logic [SW-1:0]        Test;
  logic [DW-1:0]        Data0;
  logic [(CH-1)*DW-1:0] Test_data;
  logic [CH*8-1:0]      point_in, LES;
  logic [DW-1:0]        Disp_num;
  logic [7:0]           point_out, blink_out;
  logic [SW-1:0]        cur_ch;

  int errors = 0;
  int checks = 0;

  logic [31:0] td [CH];
  logic [7:0]  pm [CH];
  logic [7:0]  bm [CH];
  logic [31:0] c0_disp;
  logic [7:0]  c0_pt, c0_bl;

  always #5 clk = ~clk;

  multi_nch_disp #(.CH(CH), .DW(DW), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .EN        (EN),
    .Test      (Test),
    .auto      (auto),
    .Data0     (Data0),
    .Test_data (Test_data),
    .point_in  (point_in),
    .LES       (LES),
    .Disp_num  (Disp_num),
    .point_out (point_out),
    .blink_out (blink_out),
    .cur_ch    (cur_ch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int k = 1; k < CH; k++) Test_data[(k-1)*DW +: DW] = td[k];
    for (int k = 0; k < CH; k++) begin
      point_in[k*8 +: 8] = pm[k];
      LES[k*8 +: 8]      = bm[k];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; EN = 1'b0; auto = 1'b0; Test = '0;
    tick();
    rst = 1'b0;
    c0_disp = 32'hAA5555AA; c0_bl = 8'hFF; c0_pt = 8'h00;
    checks++; if (Disp_num !== 32'hAA5555AA) begin errors++;
      $display("FAIL reset_disp: got %h want aa5555aa", Disp_num); end
    checks++; if (blink_out !== 8'hFF) begin errors++;
      $display("FAIL reset_blink: got %h want ff", blink_out); end
    checks++; if (point_out !== 8'h00) begin errors++;
      $display("FAIL reset_point: got %h want 00", point_out); end
    checks++; if (cur_ch !== 3'd0) begin errors++;
      $display("FAIL reset_ch: got %0d want 0", cur_ch); end
  endtask

  task automatic test_en_latch();
    Data0 = 32'h12345678; bm[0] = 8'h0F; pm[0] = 8'h81; pack();
    Test = 3'd0; EN = 1'b1;
    tick();
    EN = 1'b0;
    checks++; if (Disp_num !== 32'hAA5555AA) begin errors++;
      $display("FAIL en_latency: got %h want aa5555aa", Disp_num); end
    tick();
    c0_disp = 32'h12345678; c0_bl = 8'h0F; c0_pt = 8'h81;
    checks++; if (Disp_num !== 32'h12345678) begin errors++;
      $display("FAIL en_disp: got %h want 12345678", Disp_num); end
    checks++; if (blink_out !== 8'h0F) begin errors++;
      $display("FAIL en_blink: got %h want 0f", blink_out); end
    checks++; if (point_out !== 8'h81) begin errors++;
      $display("FAIL en_point: got %h want 81", point_out); end
    Data0 = 32'hDEADBEEF; bm[0] = 8'h00; pm[0] = 8'h00; pack();
    tick(); tick();
    checks++; if (Disp_num !== 32'h12345678 || blink_out !== 8'h0F || point_out !== 8'h81)
    begin errors++;
      $display("FAIL en_hold: got %h/%h/%h want 12345678/0f/81", Disp_num, blink_out, point_out);
    end
  endtask

  task automatic test_manual();
    for (int k = 1; k < CH; k++) begin
      td[k] = 32'(32'h1111_1111 * k);
      pm[k] = 8'(k * 3 + 1);
      bm[k] = 8'(k << 4);
    end
    td[5] = 32'hCAFEF00D; bm[5] = 8'h3C; pm[5] = 8'h5A; pack();
    Test = 3'd5;
    tick();
    checks++; if (cur_ch !== 3'd5) begin errors++;
      $display("FAIL man5_ch: got %0d want 5", cur_ch); end
    checks++; if (Disp_num !== 32'hCAFEF00D) begin errors++;
      $display("FAIL man5_disp: got %h want cafef00d", Disp_num); end
    checks++; if (blink_out !== 8'h3C || point_out !== 8'h5A) begin errors++;
      $display("FAIL man5_masks: got %h/%h want 3c/5a", blink_out, point_out); end
    Test = 3'd3;
    tick();
    checks++; if (cur_ch !== 3'd3 || Disp_num !== td[3]) begin errors++;
      $display("FAIL man3: got ch %0d %h want ch 3 %h", cur_ch, Disp_num, td[3]); end
    td[3] = 32'h0BADCAFE; pack();
    tick();
    checks++; if (Disp_num !== 32'h0BADCAFE) begin errors++;
      $display("FAIL man3_change: got %h want 0badcafe", Disp_num); end
    Test = 3'd0;
    tick();
    checks++; if (Disp_num !== c0_disp || point_out !== c0_pt) begin errors++;
      $display("FAIL man0: got %h/%h want %h/%h", Disp_num, point_out, c0_disp, c0_pt); end
  endtask

  task automatic test_en_same_edge();
    Test = 3'd5;
    tick();
    Data0 = 32'hA1B2C3D4; EN = 1'b1; Test = 3'd0;
    tick();
    EN = 1'b0;
    checks++; if (cur_ch !== 3'd0 || Disp_num !== 32'h12345678) begin errors++;
      $display("FAIL same_edge_old: got ch %0d %h want ch 0 12345678", cur_ch, Disp_num); end
    tick();
    c0_disp = 32'hA1B2C3D4;
    checks++; if (Disp_num !== 32'hA1B2C3D4) begin errors++;
      $display("FAIL same_edge_new: got %h want a1b2c3d4", Disp_num); end
  endtask

`ifdef MULTI_NCH_DISP_AUTOSCAN_EN
  task automatic test_auto_scan();
    int ech;
    logic [31:0] edisp;
    Test = 3'd6;
    tick();
    checks++; if (cur_ch !== 3'd6) begin errors++;
      $display("FAIL auto_pre: got %0d want 6", cur_ch); end
    auto = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      tick();
      if (i == 0) Test = 3'd1;
      ech = (i < 4) ? 6 : (i < 8) ? 7 : (i < 12) ? 0 : (i < 16) ? 1 : 2;
      edisp = (ech == 0) ? c0_disp : td[ech];
      checks++; if (int'(cur_ch) != ech || Disp_num !== edisp) begin errors++;
        $display("FAIL auto_step%0d: got ch %0d %h want ch %0d %h", i, cur_ch, Disp_num,
                 ech, edisp);
      end
    end
    Test = 3'd3; auto = 1'b0;
    tick();
    checks++; if (cur_ch !== 3'd3 || Disp_num !== td[3]) begin errors++;
      $display("FAIL auto_exit: got ch %0d %h want ch 3 %h", cur_ch, Disp_num, td[3]); end
    auto = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    c0_disp = 32'hAA5555AA; c0_bl = 8'hFF; c0_pt = 8'h00;
    checks++; if (cur_ch !== 3'd0 || Disp_num !== 32'hAA5555AA || blink_out !== 8'hFF ||
                  point_out !== 8'h00) begin errors++;
      $display("FAIL auto_rst: got ch %0d %h/%h/%h want ch 0 aa5555aa/ff/00", cur_ch, Disp_num,
               blink_out, point_out);
    end
    rst = 1'b0; auto = 1'b0; Test = 3'd5;
    tick();
    checks++; if (cur_ch !== 3'd5) begin errors++;
      $display("FAIL auto_rst_manual: got %0d want 5", cur_ch); end
  endtask
`else
  task automatic test_no_auto();
    Test = 3'd4; auto = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (cur_ch !== 3'd4 || Disp_num !== td[4]) begin errors++;
        $display("FAIL noauto_step%0d: got ch %0d %h want ch 4 %h", i, cur_ch, Disp_num, td[4]);
      end
    end
    auto = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b0; EN = 1'b0; auto = 1'b0; Test = '0; Data0 = '0;
    for (int k = 0; k < CH; k++) begin td[k] = '0; pm[k] = '0; bm[k] = '0; end
    pack();
    test_reset();
    test_en_latch();
    test_manual();
    test_en_same_edge();
`ifdef MULTI_NCH_DISP_AUTOSCAN_EN
    test_auto_scan();
`else
    test_no_auto();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_nch_disp.md
MULTI_NCH_DISP -- requirements
Module: multi_nch_disp

Interface
REQ-001 Parameter CH, default 8, number of display channels (2..16).
REQ-002 Parameter DW, default 32, display data width per channel.
REQ-003 Parameter DWELL, default 50_000_000, clk cycles per channel in auto-scan.
REQ-004 Localparam SW = $clog2(CH), channel-select width.
REQ-005 clk  in  1  single clock; all state changes on posedge.
REQ-006 rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-007 EN  in  1  CPU latch strobe for channel 0 data, point and blink.
REQ-008 Test  in  SW  manual channel select.
REQ-009 auto  in  1  auto-scan request level.
REQ-010 Data0  in  DW  CPU display data for channel 0.
REQ-011 Test_data  in  (CH-1)*DW  packed channels 1..CH-1, channel k at [k*DW-1 -: DW].
REQ-012 point_in  in  CH*8  packed point masks, channel k at [k*8+7 : k*8].
REQ-013 LES  in  CH*8  packed blink masks, same packing as point_in.
REQ-014 Disp_num  out  DW  selected display data, registered.
REQ-015 point_out  out  8  selected point mask, registered.
REQ-016 blink_out  out  8  selected blink mask, registered.
REQ-017 cur_ch  out  SW  channel currently driven on outputs, registered.

Function
REQ-018 Channel 0 registers disp_r, blink_r and point_r SHALL load Data0, LES[7:0] and point_in[7:0] on a posedge with EN=1, and hold when EN=0.
REQ-019 For channels 1..CH-1, outputs SHALL take Test_data, LES and point_in slices directly, with no extra latching.
REQ-020 Disp_num, point_out and blink_out SHALL be registered: they show channel cur_ch's values sampled on the same edge that sets cur_ch.
REQ-021 Output latency SHALL be 1 cycle from a Test or input change, and 2 cycles from an EN=1 edge to the new channel-0 value on the outputs.
REQ-022 FSM SHALL have two states: MANUAL and AUTO.
REQ-023 In MANUAL, cur_ch SHALL load Test each cycle; Test >= CH SHALL select channel 0.
REQ-024 MANUAL->AUTO SHALL occur on the first edge with auto=1; cur_ch holds its value and the dwell counter clears to 0.
REQ-025 In AUTO, the dwell counter SHALL increment each cycle; at DWELL-1 it clears and cur_ch advances by 1, wrapping CH-1->0.
REQ-026 AUTO->MANUAL SHALL occur on the first edge with auto=0; cur_ch loads Test on that edge and the counter clears.
REQ-027 The dwell counter SHALL be wide enough for DWELL-1; DWELL=1 SHALL advance cur_ch every cycle.
REQ-028 If EN=1 lands on the same edge that cur_ch becomes 0, the outputs SHALL show the old channel-0 value for that cycle and the new value next cycle.
REQ-029 Test changes while in AUTO SHALL be ignored.

Reset
REQ-030 On rst=1 at posedge: disp_r=32'hAA5555AA (low DW bits, zero-extended if DW>32), blink_r=8'hFF, point_r=8'h00.
REQ-031 On the same rst=1 edge: FSM=MANUAL, cur_ch=0, counter=0, Disp_num=32'hAA5555AA (sized as in REQ-030), blink_out=8'hFF, point_out=8'h00.
REQ-032 rst SHALL take priority over EN and auto; reset mid-scan SHALL abandon the scan.

Configuration
REQ-033 Macro MULTI_NCH_DISP_AUTOSCAN_EN defined SHALL compile in the AUTO state and dwell counter, with behaviour per REQ-022..029.
REQ-034 With MULTI_NCH_DISP_AUTOSCAN_EN undefined, auto SHALL be ignored, no counter SHALL be built, and the block SHALL behave permanently as MANUAL.

Verification (CH=8, DW=32, DWELL=4, macro defined unless noted)
REQ-035 Reset check: rst=1 for 1 cycle, Test=0 -> Disp_num=AA5555AA, blink_out=FF, point_out=00, cur_ch=0 after that edge.
REQ-036 EN latch: Data0=12345678, LES[7:0]=0F, point_in[7:0]=81, EN=1 for 1 cycle, Test=0 -> outputs 12345678/0F/81 two edges after the EN edge; later Data0 changes with EN=0 leave outputs unchanged.
REQ-037 Manual select: Test=5, channel-5 data=CAFEF00D, LES[47:40]=3C -> Disp_num=CAFEF00D, blink_out=3C one edge later.
REQ-038 Auto-scan wrap: auto=1 from cur_ch=6 -> cur_ch holds 6 for 4 cycles, then 7 for 4 cycles, then 0; outputs track cur_ch.
REQ-039 Exit and reset: auto drops at cur_ch=2 with Test=3 -> cur_ch=3 next edge; rst during AUTO -> cur_ch=0, FSM=MANUAL, outputs at reset values.
REQ-040 Macro undefined: auto=1 held for 20 cycles, Test=4 -> cur_ch stays 4 throughout.
